// File: rtl/hero_pkg.sv
// Shared constants, FSM encoding and the combo multiplier rule for the
// rhythm-game hit judge.
package hero_pkg;

    localparam int SCREEN_HEIGHT = 480;
    localparam int NUM_KEYS      = 4;

    localparam int ZONE_TOP_DEF  = 420;
    localparam int ZONE_BOT_DEF  = 470;
    localparam int PERF_TOP_DEF  = 440;
    localparam int PERF_BOT_DEF  = 455;

    localparam int GOOD_PTS_DEF  = 10;
    localparam int PERF_PTS_DEF  = 20;

    localparam logic [2:0] MULT_CAP = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } judge_state_e;

    // One extra multiplier step per ten hits of streak, capped.
    function automatic logic [2:0] combo_mult(input logic [7:0] combo);
        logic [7:0] m;
        m = 8'd1 + (combo / 8'd10);
        if (m > {5'd0, MULT_CAP}) begin
            m = {5'd0, MULT_CAP};
        end
        return m[2:0];
    endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Game-side bundle between the note generator / buttons and the hit judge.
interface hit_judge_if;
    import hero_pkg::*;

    logic [NUM_KEYS-1:0] keys;
    logic                note_active;
    logic [1:0]          active_column;
    logic [9:0]          note_y_position;
    logic                game_over;

    logic                hit;
    logic                perfect;
    logic                miss;
    logic                wrong_press;
    logic [15:0]         score;
    logic [7:0]          combo;
    logic [7:0]          max_combo;
    logic [2:0]          multiplier;

    modport master (
        output keys, note_active, active_column, note_y_position, game_over,
        input  hit, perfect, miss, wrong_press, score, combo, max_combo, multiplier
    );

    modport slave (
        input  keys, note_active, active_column, note_y_position, game_over,
        output hit, perfect, miss, wrong_press, score, combo, max_combo, multiplier
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes one raw button, debounces it, and emits a one-cycle pulse
// when the debounced level rises.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // The counter runs only while the synced sample disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_comb begin
        sync_d  = {sync_q[0], key_raw};
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            press_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/hit_judge.sv
// Judges button presses against the falling note: hit/perfect/miss/wrong
// pulses plus score, combo and multiplier bookkeeping.
module hit_judge
    import hero_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ZONE_TOP        = ZONE_TOP_DEF,
    parameter int ZONE_BOT        = ZONE_BOT_DEF,
    parameter int PERF_TOP        = PERF_TOP_DEF,
    parameter int PERF_BOT        = PERF_BOT_DEF,
    parameter int GOOD_PTS        = GOOD_PTS_DEF,
    parameter int PERF_PTS        = PERF_PTS_DEF
) (
    input logic       clk,
    input logic       rst,
    hit_judge_if.slave bus
);

    localparam logic [9:0]  Y_ZONE_TOP = 10'(ZONE_TOP);
    localparam logic [9:0]  Y_ZONE_BOT = 10'(ZONE_BOT);
    localparam logic [9:0]  Y_PERF_TOP = 10'(PERF_TOP);
    localparam logic [9:0]  Y_PERF_BOT = 10'(PERF_BOT);
    localparam logic [16:0] GOOD_ADD   = 17'(GOOD_PTS);
    localparam logic [16:0] PERF_ADD   = 17'(PERF_PTS);

    logic [NUM_KEYS-1:0] presses;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk    (clk),
            .rst    (rst),
            .key_raw(bus.keys[i]),
            .press  (presses[i])
        );
    end

    judge_state_e state_q, state_d;
    logic         note_q, note_d;
    logic         hit_q, hit_d;
    logic         perfect_q, perfect_d;
    logic         miss_q, miss_d;
    logic         wrong_q, wrong_d;
    logic [15:0]  score_q, score_d;
    logic [7:0]   combo_q, combo_d;
    logic [7:0]   max_combo_q, max_combo_d;
    logic [2:0]   mult_q, mult_d;

    logic         note_rise, note_fall;
    logic         any_press, one_press, on_column;
    logic         in_zone, in_perf, is_hit;
    logic [16:0]  points, score_sum;

    always_comb begin
        note_d    = bus.note_active;
        note_rise = bus.note_active && !note_q;
        note_fall = !bus.note_active && note_q;
        any_press = |presses;
        one_press = $onehot(presses);
        on_column = presses[bus.active_column];
        in_zone   = (bus.note_y_position >= Y_ZONE_TOP) && (bus.note_y_position <= Y_ZONE_BOT);
        in_perf   = (bus.note_y_position >= Y_PERF_TOP) && (bus.note_y_position <= Y_PERF_BOT);
        is_hit    = (state_q == ST_ARMED) && one_press && on_column && in_zone;
        points    = in_perf ? PERF_ADD : GOOD_ADD;
        score_sum = {1'b0, score_q} + (points * {14'd0, combo_mult(combo_q)});

        state_d     = state_q;
        hit_d       = 1'b0;
        perfect_d   = 1'b0;
        miss_d      = 1'b0;
        wrong_d     = 1'b0;
        score_d     = score_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;

        // A hit takes priority over a simultaneous note fall; the fall still
        // returns the FSM to IDLE so the next note can arm.
        if (!bus.game_over) begin
            unique case (state_q)
                ST_IDLE: begin
                    wrong_d = any_press;
                    if (note_rise) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (is_hit) begin
                        hit_d     = 1'b1;
                        perfect_d = in_perf;
                        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        combo_d   = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
                        state_d   = note_fall ? ST_IDLE : ST_DONE;
                    end else begin
                        if (any_press) begin
                            wrong_d = 1'b1;
                            combo_d = 8'd0;
                        end
                        if (note_fall) begin
                            miss_d  = 1'b1;
                            combo_d = 8'd0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    wrong_d = any_press;
                    if (note_fall) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (combo_d > max_combo_q) max_combo_d = combo_d;
        mult_d = combo_mult(combo_d);
    end

    // note_q resets high so a note already on screen when reset drops is
    // not seen as a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            note_q      <= 1'b1;
            hit_q       <= 1'b0;
            perfect_q   <= 1'b0;
            miss_q      <= 1'b0;
            wrong_q     <= 1'b0;
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            mult_q      <= 3'd1;
        end else begin
            state_q     <= state_d;
            note_q      <= note_d;
            hit_q       <= hit_d;
            perfect_q   <= perfect_d;
            miss_q      <= miss_d;
            wrong_q     <= wrong_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            mult_q      <= mult_d;
        end
    end

    assign bus.hit         = hit_q;
    assign bus.perfect     = perfect_q;
    assign bus.miss        = miss_q;
    assign bus.wrong_press = wrong_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.max_combo   = max_combo_q;
    assign bus.multiplier  = mult_q;

endmodule

// File: tb/tb_hit_judge.sv
// Randomized bench for hit_judge, compared note-by-note against a
// rule-level model of scoring, combo and event counts.
module tb_hit_judge;

    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic clk = 1'b0;
    logic rst;

    hit_judge_if bus ();

    hit_judge #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    int m_score, m_combo, m_max;
    int m_col, m_y;
    bit m_armed;
    int exp_hit, exp_perf, exp_miss, exp_wrong;
    int cnt_hit, cnt_perf, cnt_miss, cnt_wrong;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.hit)         cnt_hit++;
            if (bus.perfect)     cnt_perf++;
            if (bus.miss)        cnt_miss++;
            if (bus.wrong_press) cnt_wrong++;
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int multOf(input int c);
        return (1 + c / 10 > 4) ? 4 : 1 + c / 10;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] k, input int hold);
        bus.keys = k;
        tick(hold);
        bus.keys = 4'b0000;
        tick(12);
    endtask

    task automatic modelPress(input logic [3:0] ev);
        int pts;
        if (ev == 4'b0000 || bus.game_over) return;
        if (m_armed && $countones(ev) == 1 && ev[m_col] && m_y >= 420 && m_y <= 470) begin
            pts = (m_y >= 440 && m_y <= 455) ? 20 : 10;
            exp_hit++;
            if (pts == 20) exp_perf++;
            m_score = m_score + pts * multOf(m_combo);
            if (m_score > 65535) m_score = 65535;
            m_combo = (m_combo == 255) ? 255 : m_combo + 1;
            if (m_combo > m_max) m_max = m_combo;
            m_armed = 1'b0;
        end else begin
            exp_wrong++;
            if (m_armed) m_combo = 0;
        end
    endtask

    task automatic doKeys(input logic [3:0] k, input int hold);
        applyStimulus(k, hold);
        if (hold >= DEB) modelPress(k);
    endtask

    task automatic doPress(input int kind);
        logic [3:0] right, other;
        right = 4'(1 << m_col);
        other = 4'(1 << ((m_col + 1 + $urandom_range(0, 2)) % 4));
        case (kind)
            0:       doKeys(right, HOLD);
            1:       doKeys(other, HOLD);
            2:       doKeys(right | other, HOLD);
            default: doKeys(right, 2);
        endcase
    endtask

    task automatic noteStart(input int col, input int y);
        m_col = col;
        m_y   = y;
        bus.active_column   = 2'(col);
        bus.note_y_position = 10'(y);
        bus.note_active     = 1'b1;
        m_armed = !bus.game_over;
        tick(3);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_score"},  int'(bus.score),      m_score);
        checkOutput({tag, "_combo"},  int'(bus.combo),      m_combo);
        checkOutput({tag, "_max"},    int'(bus.max_combo),  m_max);
        checkOutput({tag, "_mult"},   int'(bus.multiplier), multOf(m_combo));
        checkOutput({tag, "_nhit"},   cnt_hit,   exp_hit);
        checkOutput({tag, "_nperf"},  cnt_perf,  exp_perf);
        checkOutput({tag, "_nmiss"},  cnt_miss,  exp_miss);
        checkOutput({tag, "_nwrong"}, cnt_wrong, exp_wrong);
    endtask

    task automatic noteEnd(input string tag);
        bus.note_active = 1'b0;
        tick(5);
        if (m_armed && !bus.game_over) begin
            exp_miss++;
            m_combo = 0;
        end
        m_armed = 1'b0;
        checkAll(tag);
    endtask

    function automatic int pickY();
        int ys[8] = '{419, 420, 439, 440, 455, 456, 470, 471};
        if ($urandom_range(0, 2) == 0) return $urandom_range(0, 480);
        return ys[$urandom_range(0, 7)];
    endfunction

    initial begin
        #5_000_000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        int s0, w0, n;
        rst = 1'b1;
        bus.keys = 4'b0000;
        bus.note_active = 1'b0;
        bus.active_column = 2'd0;
        bus.note_y_position = 10'd0;
        bus.game_over = 1'b0;
        m_score = 0; m_combo = 0; m_max = 0; m_armed = 1'b0;
        exp_hit = 0; exp_perf = 0; exp_miss = 0; exp_wrong = 0;
        cnt_hit = 0; cnt_perf = 0; cnt_miss = 0; cnt_wrong = 0;
        tick(3);
        rst = 1'b0;
        tick(2);
        checkAll("reset");

        noteStart(2, 445);
        doKeys(4'b0100, HOLD);
        noteEnd("perfect_col2");
        checkOutput("perfect_col2_score_const", int'(bus.score), 20);

        noteStart(1, 425);
        doKeys(4'b1000, HOLD);
        checkOutput("wrong_then_combo", int'(bus.combo), 0);
        doKeys(4'b0010, HOLD);
        noteEnd("wrong_then_hit");
        checkOutput("wrong_then_hit_score_const", int'(bus.score), 30);

        noteStart(0, 480);
        noteEnd("unpressed_miss");

        for (int i = 0; i < 10; i++) begin
            noteStart(i % 4, 447);
            doPress(0);
            noteEnd("streak");
        end
        s0 = m_score;
        noteStart(3, 450);
        doPress(0);
        noteEnd("streak_11th");
        checkOutput("streak_11th_add", int'(bus.score) - s0, 40);
        checkOutput("streak_11th_max", int'(bus.max_combo), 11);

        w0 = cnt_wrong;
        applyStimulus(4'b0001, 2);
        checkOutput("glitch_no_event", cnt_wrong - w0, 0);
        doKeys(4'b0001, 6);
        checkOutput("held_one_event", cnt_wrong - w0, 1);
        checkAll("debounce");

        for (int i = 0; i < 40; i++) begin
            noteStart($urandom_range(0, 3), pickY());
            n = $urandom_range(0, 2);
            for (int p = 0; p < n; p++) doPress($urandom_range(0, 3));
            noteEnd("random");
        end

        bus.game_over = 1'b1;
        noteStart(1, 447);
        doPress(0);
        doKeys(4'b0100, HOLD);
        noteEnd("game_over");
        bus.game_over = 1'b0;
        tick(2);

        for (int i = 0; i < 2000 && m_score < 65535; i++) begin
            noteStart($urandom_range(0, 3), 447);
            doPress(0);
            noteEnd("fill");
        end
        noteStart(2, 447);
        doPress(0);
        noteEnd("saturate");
        checkOutput("saturate_score_const", int'(bus.score), 65535);
        checkOutput("saturate_combo_const", int'(bus.combo), 255);

        noteStart(0, 445);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_rst_score",  int'(bus.score), 0);
        checkOutput("async_rst_combo",  int'(bus.combo), 0);
        checkOutput("async_rst_max",    int'(bus.max_combo), 0);
        checkOutput("async_rst_mult",   int'(bus.multiplier), 1);
        checkOutput("async_rst_pulses", int'({bus.hit, bus.perfect, bus.miss, bus.wrong_press}), 0);
        tick(2);
        rst = 1'b0;
        m_score = 0; m_combo = 0; m_max = 0; m_armed = 1'b0;
        tick(2);
        doKeys(4'b0001, HOLD);
        noteEnd("discarded_note");
        noteStart(0, 445);
        doPress(0);
        noteEnd("resume");
        checkOutput("resume_score_const", int'(bus.score), 20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable samples before a key change is accepted.
REQ-002 Parameter ZONE_TOP, default 420, first note_y_position value inside the hit zone.
REQ-003 Parameter ZONE_BOT, default 470, last note_y_position value inside the hit zone.
REQ-004 Parameter PERF_TOP / PERF_BOT, default 440 / 455, inclusive perfect sub-window.
REQ-005 Parameters GOOD_PTS / PERF_PTS, default 10 / 20, base points per hit.
REQ-006 clk  in  1  system clock; one clock domain.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 keys  in  4  raw, asynchronous player buttons, bit n = column n, active-high.
REQ-009 note_active  in  1  falling note present (from the note generator).
REQ-010 active_column  in  2  column of the current note.
REQ-011 note_y_position  in  10  vertical position of the current note, 0 to 480.
REQ-012 game_over  in  1  freezes judging when high.
REQ-013 hit / perfect / miss / wrong_press  out  1 each  single-cycle event pulses.
REQ-014 score  out  16  accumulated score; combo  out  8  current streak; max_combo  out  8  best streak; multiplier  out  3  current multiplier.

Function
REQ-015 Each key SHALL pass through a 2-flop synchronizer and debounce counter; a press event is one cycle, issued when the debounced level rises.
REQ-016 FSM states SHALL be IDLE, ARMED and DONE: IDLE->ARMED on note_active rising; ARMED->DONE on hit; ARMED->IDLE on note_active falling (miss); DONE->IDLE on note_active falling.
REQ-017 Hit condition SHALL be: ARMED, exactly one press event this cycle, that press is on active_column, and ZONE_TOP <= note_y_position <= ZONE_BOT.
REQ-018 On hit: hit pulses; perfect also pulses if PERF_TOP <= y <= PERF_BOT; score += (PERF_PTS or GOOD_PTS) * multiplier; combo increments.
REQ-019 Any press event in ARMED that is not a hit SHALL pulse wrong_press and clear combo to 0; state stays ARMED.
REQ-020 Any press event in IDLE or DONE SHALL pulse wrong_press and leave combo and score unchanged.
REQ-021 note_active falling while ARMED SHALL pulse miss and clear combo to 0.
REQ-022 multiplier SHALL be min(1 + combo/10, 4), computed from combo before the current update.
REQ-023 score SHALL saturate at 16'hFFFF; combo SHALL saturate at 255.
REQ-024 max_combo SHALL update to the new combo whenever the new combo exceeds it.
REQ-025 A hit and a note_active fall in the same cycle SHALL judge as a hit, not a miss.
REQ-026 While game_over is high, no pulses are produced, and score, combo and max_combo hold; the synchronizers keep running.
REQ-027 All outputs SHALL be registered; pulses appear the cycle after the press event or note_active edge is detected.

Reset
REQ-028 rst SHALL force state IDLE, all pulses 0, score 0, combo 0, max_combo 0, multiplier 1, and clear the synchronizers and debounce counters, without waiting for a clock edge.
REQ-029 Reset asserted mid-note SHALL discard that note; after release, judging resumes at the next note_active rising edge.

Structure
REQ-030 Shared package hero_pkg SHALL hold the screen height (480), the zone/window defaults, the point constants, the multiplier cap, and the FSM state encoding.
REQ-031 Per-key synchronize+debounce+edge logic SHALL be a sub-module key_debounce, instanced 4 times.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Note in column 2 at y=445, press keys[2] -> hit=1, perfect=1, score 0->20, combo 1.
REQ-033 Note in column 1 at y=425, press keys[3] then keys[1] -> wrong_press, combo 0, then hit, score +10, perfect=0.
REQ-034 Note never pressed, note_active falls at y=480 -> miss pulse, combo cleared, state IDLE.
REQ-035 Ten consecutive perfect hits -> multiplier 2 on the 11th hit, which adds 40; max_combo=11.
REQ-036 keys[0] bounces with a 2-cycle glitch -> no event; held for 6 cycles -> exactly one event.
REQ-037 score preloaded to 65530 by repeated hits, one further hit -> score 65535; assert rst mid-note -> all outputs reset immediately.
